// File: rtl/rider_sense_seq_pkg.sv
// Shared types and constants for the load-cell sequencer: channel map, FSM
// encoding, flag bundle, settle-timer limits and the balance/weight compare.
package rider_sense_seq_pkg;

    localparam logic [2:0]  LFT_CH        = 3'd0;
    localparam logic [2:0]  RGHT_CH       = 3'd4;

    localparam logic [14:0] TMR_FULL_FAST = 15'h7FFF;
    localparam logic [25:0] TMR_FULL      = 26'h3FFFFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNV_L  = 3'd1,
        WAIT_L = 3'd2,
        CNV_R  = 3'd3,
        WAIT_R = 3'd4,
        UPDATE = 3'd5
    } rider_seq_state_t;

    typedef struct packed {
        logic sum_gt_min;
        logic sum_lt_min;
        logic diff_gt_1_4;
        logic diff_gt_15_16;
    } rider_flags_t;

    // "No rider" until the first round completes.
    localparam rider_flags_t FLAGS_RST = '{
        sum_gt_min:    1'b0,
        sum_lt_min:    1'b1,
        diff_gt_1_4:   1'b0,
        diff_gt_15_16: 1'b0
    };

    function automatic rider_flags_t calc_flags(
        input logic [11:0] lft,
        input logic [11:0] rght,
        input logic [12:0] hi_th,
        input logic [12:0] lo_th
    );
        logic [12:0]  sum;
        logic [12:0]  diff;
        logic [12:0]  sum_1_4;
        logic [12:0]  sum_15_16;
        rider_flags_t f;
        sum       = {1'b0, lft} + {1'b0, rght};
        diff      = (lft >= rght) ? {1'b0, lft - rght} : {1'b0, rght - lft};
        sum_1_4   = sum >> 2;
        sum_15_16 = sum - (sum >> 4);
        f.sum_gt_min    = (sum > hi_th);
        f.sum_lt_min    = (sum < lo_th);
        f.diff_gt_1_4   = (diff > sum_1_4);
        f.diff_gt_15_16 = (diff > sum_15_16);
        return f;
    endfunction

endpackage

// File: rtl/rider_sense_seq_if.sv
// Handshake between the load-cell sequencer (master) and the shared A2D (slave).
interface rider_sense_seq_if;

    logic        strt_cnv;
    logic [2:0]  chnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    modport master (
        output strt_cnv,
        output chnl,
        input  cnv_cmplt,
        input  res
    );

    modport slave (
        input  strt_cnv,
        input  chnl,
        output cnv_cmplt,
        output res
    );

endinterface

// File: rtl/rider_settle_tmr.sv
// Free-running rider-settle timer: saturates at full count, cleared by the
// steering-enable SM. FAST_SIM shortens the full count for simulation.
module rider_settle_tmr
    import rider_sense_seq_pkg::*;
#(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_tmr,
    output logic tmr_full
);

    localparam logic [25:0] FULL_CNT = FAST_SIM ? 26'(TMR_FULL_FAST) : TMR_FULL;

    logic [25:0] cnt_q;
    logic [25:0] cnt_d;

    // NOTE: combinational next-state uses blocking '=' with a default first so no
    // path leaves cnt_d unassigned (which would infer a latch); the register below
    // uses non-blocking '<=' so every flop samples pre-edge values.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_tmr) begin
            cnt_d = '0;
        end else if (cnt_q != FULL_CNT) begin
            cnt_d = cnt_q + 26'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmr_full = (cnt_q == FULL_CNT);

endmodule

// File: rtl/rider_sense_seq.sv
// Round-robins the shared A2D over the left/right load cells and publishes the
// weight/balance flags plus the settle timer used by the steering-enable SM.
module rider_sense_seq
    import rider_sense_seq_pkg::*;
#(
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [11:0] WT_HYSTERESIS = 12'h040,
    parameter logic [15:0] SAMPLE_GAP    = 16'd4096,
    parameter bit          FAST_SIM      = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_tmr,
    output logic               tmr_full,
    rider_sense_seq_if.master  a2d,
    output logic [11:0]        lft_ld,
    output logic [11:0]        rght_ld,
    output logic               sum_gt_min,
    output logic               sum_lt_min,
    output logic               diff_gt_1_4,
    output logic               diff_gt_15_16,
    output logic               vld
);

    localparam logic [12:0] HI_TH = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
    localparam logic [12:0] LO_TH = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

    rider_seq_state_t state_q, state_d;
    logic [15:0]      gap_q, gap_d;
    logic [11:0]      lft_q, lft_d;
    logic [11:0]      rght_q, rght_d;
    rider_flags_t     flags_q, flags_d;
    logic             vld_q, vld_d;

    rider_settle_tmr #(
        .FAST_SIM (FAST_SIM)
    ) u_settle_tmr (
        .clk      (clk),
        .rst      (rst),
        .clr_tmr  (clr_tmr),
        .tmr_full (tmr_full)
    );

    // Gap counter parks at or above SAMPLE_GAP in IDLE, so counting from 0 after
    // UPDATE leaves SAMPLE_GAP idle clocks between the vld pulse and strt_cnv.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        flags_d = flags_q;
        vld_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gap_q >= SAMPLE_GAP) begin
                    state_d = CNV_L;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            CNV_L: state_d = WAIT_L;
            WAIT_L: begin
                if (a2d.cnv_cmplt) begin
                    lft_d   = a2d.res;
                    state_d = CNV_R;
                end
            end
            CNV_R: state_d = WAIT_R;
            WAIT_R: begin
                if (a2d.cnv_cmplt) begin
                    rght_d  = a2d.res;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                flags_d = calc_flags(lft_q, rght_q, HI_TH, LO_TH);
                vld_d   = 1'b1;
                gap_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gap resets "already elapsed" so the first round starts one clock after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= SAMPLE_GAP;
            lft_q   <= '0;
            rght_q  <= '0;
            flags_q <= FLAGS_RST;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            flags_q <= flags_d;
            vld_q   <= vld_d;
        end
    end

    // Channel is decoded from state so it is held through the whole wait.
    assign a2d.strt_cnv = (state_q == CNV_L) || (state_q == CNV_R);
    assign a2d.chnl     = ((state_q == CNV_R) || (state_q == WAIT_R)) ? RGHT_CH : LFT_CH;

    assign lft_ld        = lft_q;
    assign rght_ld       = rght_q;
    assign sum_gt_min    = flags_q.sum_gt_min;
    assign sum_lt_min    = flags_q.sum_lt_min;
    assign diff_gt_1_4   = flags_q.diff_gt_1_4;
    assign diff_gt_15_16 = flags_q.diff_gt_15_16;
    assign vld           = vld_q;

endmodule

// File: tb/tb_rider_sense_seq.sv
// Directed bench for rider_sense_seq: stimulus and sampling on the falling edge,
// expected values hand-computed per scenario.
module tb_rider_sense_seq;
    import rider_sense_seq_pkg::*;

    localparam logic [15:0] GAP = 16'd100;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_tmr;
    logic        tmr_full;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;
    logic        vld;

    int n_pass  = 0;
    int n_total = 0;

    logic [11:0] m_lft;
    logic [11:0] m_rght;

    rider_sense_seq_if a2d ();

    always #5 clk = ~clk;

    rider_sense_seq #(
        .MIN_RIDER_WT  (12'h200),
        .WT_HYSTERESIS (12'h040),
        .SAMPLE_GAP    (GAP),
        .FAST_SIM      (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clr_tmr       (clr_tmr),
        .tmr_full      (tmr_full),
        .a2d           (a2d),
        .lft_ld        (lft_ld),
        .rght_ld       (rght_ld),
        .sum_gt_min    (sum_gt_min),
        .sum_lt_min    (sum_lt_min),
        .diff_gt_1_4   (diff_gt_1_4),
        .diff_gt_15_16 (diff_gt_15_16),
        .vld           (vld)
    );

    function automatic logic [3:0] flags_now();
        return {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16};
    endfunction

    // One full left/right round; optionally pulses cnv_cmplt during CNV_L.
    task automatic run_round(input logic [11:0] l, input logic [11:0] r,
                             input logic [3:0] exp_flags, input bit spur,
                             input string tag);
        int n;
        n = 0;
        while (a2d.strt_cnv !== 1'b1 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if ({a2d.strt_cnv, a2d.chnl} !== {1'b1, LFT_CH})
            $display("FAIL %s strt_l: got strt=%b chnl=%0d expected strt=1 chnl=%0d",
                     tag, a2d.strt_cnv, a2d.chnl, LFT_CH);
        else n_pass++;
        a2d.cnv_cmplt = spur;
        a2d.res       = 12'h777;
        @(negedge clk);
        a2d.cnv_cmplt = 1'b0;
        n_total++;
        if ({a2d.strt_cnv, a2d.chnl, lft_ld} !== {1'b0, LFT_CH, m_lft})
            $display("FAIL %s wait_l: got strt=%b chnl=%0d lft=%h expected strt=0 chnl=%0d lft=%h",
                     tag, a2d.strt_cnv, a2d.chnl, lft_ld, LFT_CH, m_lft);
        else n_pass++;
        repeat (18) @(negedge clk);
        a2d.res       = l;
        a2d.cnv_cmplt = 1'b1;
        @(negedge clk);
        a2d.cnv_cmplt = 1'b0;
        a2d.res       = 12'hFFF;
        m_lft         = l;
        n_total++;
        if ({a2d.strt_cnv, a2d.chnl, lft_ld} !== {1'b1, RGHT_CH, l})
            $display("FAIL %s strt_r: got strt=%b chnl=%0d lft=%h expected strt=1 chnl=%0d lft=%h",
                     tag, a2d.strt_cnv, a2d.chnl, lft_ld, RGHT_CH, l);
        else n_pass++;
        @(negedge clk);
        repeat (18) @(negedge clk);
        n_total++;
        if ({a2d.strt_cnv, a2d.chnl, vld} !== {1'b0, RGHT_CH, 1'b0})
            $display("FAIL %s wait_r: got strt=%b chnl=%0d vld=%b expected strt=0 chnl=%0d vld=0",
                     tag, a2d.strt_cnv, a2d.chnl, vld, RGHT_CH);
        else n_pass++;
        a2d.res       = r;
        a2d.cnv_cmplt = 1'b1;
        @(negedge clk);
        a2d.cnv_cmplt = 1'b0;
        a2d.res       = 12'hFFF;
        m_rght        = r;
        n = 0;
        while (vld !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n !== 1)
            $display("FAIL %s vld_latency: got %0d clks expected 1", tag, n);
        else n_pass++;
        n_total++;
        if ({flags_now(), rght_ld} !== {exp_flags, r})
            $display("FAIL %s flags: got flags=%b rght=%h expected flags=%b rght=%h",
                     tag, flags_now(), rght_ld, exp_flags, r);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        clr_tmr       = 1'b0;
        a2d.cnv_cmplt = 1'b0;
        a2d.res       = 12'h000;
        m_lft         = 12'h000;
        m_rght        = 12'h000;
        repeat (3) @(negedge clk);
        n_total++;
        if ({a2d.strt_cnv, a2d.chnl, lft_ld, rght_ld, flags_now(), vld, tmr_full} !==
            {1'b0, LFT_CH, 12'h000, 12'h000, 4'b0100, 1'b0, 1'b0})
            $display("FAIL reset_state: got strt=%b chnl=%0d l=%h r=%h flags=%b vld=%b full=%b expected 0/0/000/000/0100/0/0",
                     a2d.strt_cnv, a2d.chnl, lft_ld, rght_ld, flags_now(), vld, tmr_full);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({a2d.strt_cnv, a2d.chnl} !== {1'b1, LFT_CH})
            $display("FAIL first_strt_clk1: got strt=%b chnl=%0d expected strt=1 chnl=0",
                     a2d.strt_cnv, a2d.chnl);
        else n_pass++;
    endtask

    task automatic test_flags();
        run_round(12'h150, 12'h150, 4'b1000, 1'b0, "balanced_heavy");
        run_round(12'h100, 12'h110, 4'b0000, 1'b0, "in_band");
        run_round(12'h300, 12'h080, 4'b1010, 1'b0, "diff_quarter");
        run_round(12'h3F0, 12'h000, 4'b1011, 1'b0, "diff_15_16");
        run_round(12'h050, 12'h060, 4'b0100, 1'b0, "light");
        run_round(12'h120, 12'h120, 4'b0000, 1'b0, "sum_eq_hi");
        run_round(12'h121, 12'h120, 4'b1000, 1'b0, "sum_hi_plus1");
        run_round(12'h0E0, 12'h0E0, 4'b0000, 1'b0, "sum_eq_lo");
        run_round(12'h0E0, 12'h0DF, 4'b0100, 1'b0, "sum_lo_minus1");
        run_round(12'h140, 12'h0C0, 4'b0000, 1'b0, "diff_eq_quarter");
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        n_total++;
        if (vld !== 1'b0)
            $display("FAIL vld_one_cycle: got vld=%b expected 0", vld);
        else n_pass++;
        n = 1;
        while (a2d.strt_cnv !== 1'b1 && n < int'(GAP) + 50) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n - 1 !== int'(GAP))
            $display("FAIL idle_gap: got %0d idle clks expected %0d", n - 1, GAP);
        else n_pass++;
        run_round(12'h222, 12'h111, 4'b1010, 1'b0, "b2b_round");
    endtask

    task automatic test_spurious();
        @(negedge clk);
        a2d.res       = 12'hABC;
        a2d.cnv_cmplt = 1'b1;
        @(negedge clk);
        a2d.cnv_cmplt = 1'b0;
        @(negedge clk);
        n_total++;
        if ({lft_ld, rght_ld, vld} !== {m_lft, m_rght, 1'b0})
            $display("FAIL spurious_idle: got l=%h r=%h vld=%b expected l=%h r=%h vld=0",
                     lft_ld, rght_ld, vld, m_lft, m_rght);
        else n_pass++;
        run_round(12'h180, 12'h180, 4'b1000, 1'b1, "spurious_cnv_l");
    endtask

    task automatic test_timer();
        int n;
        @(negedge clk);
        clr_tmr = 1'b1;
        @(negedge clk);
        clr_tmr = 1'b0;
        n_total++;
        if (tmr_full !== 1'b0)
            $display("FAIL tmr_after_clr: got %b expected 0", tmr_full);
        else n_pass++;
        n = 0;
        while (tmr_full !== 1'b1 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n !== 32767)
            $display("FAIL tmr_rise: got %0d clks expected 32767", n);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_total++;
        if (tmr_full !== 1'b1)
            $display("FAIL tmr_hold: got %b expected 1", tmr_full);
        else n_pass++;
        clr_tmr = 1'b1;
        @(negedge clk);
        clr_tmr = 1'b0;
        n_total++;
        if (tmr_full !== 1'b0)
            $display("FAIL tmr_clr_full: got %b expected 0", tmr_full);
        else n_pass++;
    endtask

    task automatic test_reset_mid_round();
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        m_lft  = 12'h000;
        m_rght = 12'h000;
        @(negedge clk);
        @(negedge clk);
        repeat (18) @(negedge clk);
        a2d.res       = 12'h222;
        a2d.cnv_cmplt = 1'b1;
        @(negedge clk);
        a2d.cnv_cmplt = 1'b0;
        @(negedge clk);
        repeat (5) @(negedge clk);
        n_total++;
        if ({a2d.chnl, lft_ld} !== {RGHT_CH, 12'h222})
            $display("FAIL pre_reset_wait_r: got chnl=%0d lft=%h expected chnl=4 lft=222",
                     a2d.chnl, lft_ld);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({a2d.strt_cnv, a2d.chnl, lft_ld, rght_ld, flags_now(), vld, tmr_full} !==
            {1'b0, LFT_CH, 12'h000, 12'h000, 4'b0100, 1'b0, 1'b0})
            $display("FAIL mid_reset_state: got strt=%b chnl=%0d l=%h r=%h flags=%b vld=%b full=%b expected 0/0/000/000/0100/0/0",
                     a2d.strt_cnv, a2d.chnl, lft_ld, rght_ld, flags_now(), vld, tmr_full);
        else n_pass++;
        a2d.res       = 12'h555;
        a2d.cnv_cmplt = 1'b1;
        @(negedge clk);
        a2d.cnv_cmplt = 1'b0;
        rst           = 1'b0;
        @(negedge clk);
        n_total++;
        if ({a2d.strt_cnv, a2d.chnl, lft_ld, rght_ld} !== {1'b1, LFT_CH, 12'h000, 12'h000})
            $display("FAIL restart_round: got strt=%b chnl=%0d l=%h r=%h expected strt=1 chnl=0 l=000 r=000",
                     a2d.strt_cnv, a2d.chnl, lft_ld, rght_ld);
        else n_pass++;
        run_round(12'h150, 12'h150, 4'b1000, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        run_round(12'h150, 12'h150, 4'b1000, 1'b0, "first_round");
        test_flags();
        test_back_to_back();
        test_spurious();
        test_timer();
        test_reset_mid_round();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
